device_arbiter_rr: RTL and testbench
====================================

# device_arbiter_rr

Parametrised successor to the two-port device arbiter: it shares one memory-mapped device among `NUM_CONTROLLERS` bus masters, such as N64 PI, USB PC and a future DMA engine. It selects requests by bank, with fixed-priority or round-robin selection. It registers the winning transaction and runs it through a small state machine. Device read acks and data go back to the granted controller only. A read-ack timeout returns an error word so a hung device cannot stall a controller forever.

## Interface
- `NUM_CONTROLLERS`, 2, number of masters (1..8).
- `ADDRESS_WIDTH`, 25, device word-address width.
- `DATA_WIDTH`, 32, data width.
- `BANK_WIDTH`, 4, bank field width.
- `DEVICE_BANK`, 0, bank value this device answers to.
- `ROUND_ROBIN`, 1, 1 = rotating priority, 0 = fixed priority (lowest index wins).
- `TIMEOUT`, 1024, read-ack timeout in cycles; 0 disables the timeout.
- `TIMEOUT_DATA`, all ones, data returned on timeout.
- `i_clk`  in  1  sole clock; all logic is rising-edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_request`  in  N  per-controller request.
- `i_write`  in  N  per-controller write flag.
- `o_busy`  out  N  per-controller back-pressure.
- `o_ack`  out  N  per-controller read-data valid, one-cycle pulse.
- `i_bank`  in  N*BANK_WIDTH  bank, controller k in slice k.
- `i_address`  in  N*ADDRESS_WIDTH  address.
- `i_data`  in  N*DATA_WIDTH  write data.
- `o_data`  out  N*DATA_WIDTH  read data; every lane carries the same word, qualified by `o_ack[k]`.
- `o_device_request`  out  1  request to device.
- `o_device_write`  out  1  registered write flag.
- `i_device_busy`  in  1  device back-pressure.
- `i_device_ack`  in  1  device read-data valid.
- `o_device_address`  out  ADDRESS_WIDTH  registered address.
- `i_device_data`  in  DATA_WIDTH  device read data.
- `o_device_data`  out  DATA_WIDTH  registered write data.
- `o_timeout`  out  1  one-cycle pulse when a read times out.

## Operation
- **Match:** `match[k] = i_request[k] && i_bank[k] == DEVICE_BANK`. Non-matching requests are invisible: busy 0, ack 0.
- **Accept:** a controller's transaction is accepted in the cycle where `match[k] && !o_busy[k]`.
- **IDLE:**
  - The winner is the first set bit of `match`. The search order is lowest index first in fixed mode, and starts at `last_grant+1` (mod N) in round-robin mode.
  - `o_busy[winner]=0`; every other matching controller sees `o_busy=1`.
  - The winner's index, write flag, address and data are registered, and the state goes to ISSUE.
  - `last_grant` updates to the winner.
- **ISSUE:**
  - `o_device_request=1` with the registered fields.
  - On `!i_device_busy` the device accepts. A write returns to IDLE; a read clears the timeout counter and goes to WAIT_ACK.
- **WAIT_ACK:**
  - On `i_device_ack`, `o_ack[grant]=1` and `o_data` equals `i_device_data`, combinationally in the same cycle, and the state returns to IDLE.
  - Otherwise the counter increments. When it reaches `TIMEOUT-1` (with `TIMEOUT` nonzero), the arbiter asserts `o_ack[grant]=1`, drives `o_data=TIMEOUT_DATA` and `o_timeout=1`, and returns to IDLE.
- **Busy outside IDLE:** in ISSUE and WAIT_ACK, `o_busy[k]=match[k]` for all k.
- **Writes:** writes are never acked; they complete at device accept.
- **Stale acks:** `i_device_ack` outside WAIT_ACK is dropped. Devices with unbounded latency must use `TIMEOUT=0`.
- **Simultaneous events:** an ack and the timeout threshold in the same cycle resolve as the ack (`o_timeout` stays 0).
- **Counter width:** `$clog2(TIMEOUT+1)`, minimum 1 bit; the counter saturates and never wraps.

## Timing
- **Reset:** asynchronous, active low. State goes to IDLE, `last_grant` to N-1 so index 0 is first after reset, and all registered fields and the counter clear.
  - All outputs are 0 while in reset, except `o_busy`, which stays combinational from `match`; it is 0 for non-matching and nonzero for matching controllers.
- **Accept:** the grant is combinational in the IDLE accept cycle, and `o_device_request` is first high on the next cycle.
- **Minimum read:**
  - Accept at cycle 0, device request at cycle 1, device accept at cycle 1 if `i_device_busy=0`.
  - Earliest ack at cycle 2; back in IDLE at cycle 3, when a new accept is possible.
- **Minimum write:** accept at cycle 0, device accept at cycle 1, IDLE at cycle 2.
- **Held request:** a controller holding a request through busy keeps its fields unchanged. A request withdrawn while busy is simply not accepted.
- **Reset mid-transaction:** the transaction is abandoned and no ack is issued.

## Structure
- **Shared package `arbiter_pkg`:** state enum (IDLE, ISSUE, WAIT_ACK), default `BANK_WIDTH` and bank constants.
- **Sub-module `arbiter_rr_select`:** combinational priority picker. Inputs: `match`, `last_grant`, mode. Outputs: winner index and valid.

## Test plan
- **Fixed priority:** N=2, `ROUND_ROBIN=0`, both controllers request the device bank at cycle 0 → k0 is accepted at cycle 0 and k1 is busy; k1 is accepted in the cycle after k0's transaction ends.
- **Round robin:** N=3, `ROUND_ROBIN=1`, all controllers request continuously with writes → grant order is 0, 1, 2, 0, with one accept every 2 cycles.
- **Read routing:** k1 reads address 0x12345; the device acks 5 cycles after accept with 0xDEADBEEF → `o_ack=2'b10` for exactly one cycle, data 0xDEADBEEF, `o_device_address=0x12345`.
- **Timeout:** `TIMEOUT=8`, the device never acks a read → `o_ack[grant]` and `o_timeout` pulse 8 cycles after device accept with data 0xFFFFFFFF; a later stale ack produces no `o_ack`.
- **Bank filter and back-pressure:** k0 requests bank `DEVICE_BANK+1` → no busy, no device request. k1 hits the device bank while `i_device_busy` is held for 4 cycles → the request stays high with stable fields, and the state advances on the first non-busy cycle.
- **Reset mid-read:** `i_reset_n` pulses low during WAIT_ACK → outputs clear immediately, no ack follows, and the next request is granted to k0 first.

Source files
------------

// File: rtl/arbiter_pkg.sv
// Shared types and constants for the device arbiter family.
package arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2
  } arb_state_t;

  localparam int unsigned DEFAULT_BANK_WIDTH  = 4;
  localparam int unsigned DEFAULT_DEVICE_BANK = 0;

  // Width of a controller index; a single controller still gets one bit.
  function automatic int unsigned index_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arbiter_rr_select.sv
// Combinational priority picker: fixed (lowest index first) or rotating
// starting one past the previous grant.
module arbiter_rr_select
  import arbiter_pkg::*;
#(
  parameter int unsigned NUM_CONTROLLERS = 2,
  parameter int unsigned INDEX_WIDTH     = index_width(NUM_CONTROLLERS)
) (
  input  logic [NUM_CONTROLLERS-1:0] match,
  input  logic [INDEX_WIDTH-1:0]     last_grant,
  input  logic                       round_robin,
  output logic [INDEX_WIDTH-1:0]     winner,
  output logic                       valid
);

  int unsigned idx;

  // Scan candidates in priority order and keep the first matching one.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int unsigned i = 0; i < NUM_CONTROLLERS; i++) begin
      if (round_robin) begin
        idx = (32'(last_grant) + 32'd1 + i) % NUM_CONTROLLERS;
      end else begin
        idx = i;
      end
      if (!valid && match[idx[INDEX_WIDTH-1:0]]) begin
        valid  = 1'b1;
        winner = idx[INDEX_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/device_arbiter_rr.sv
// Shares one memory-mapped device among NUM_CONTROLLERS bus masters.
// Requests are filtered by bank, arbitrated, registered and run through
// IDLE -> ISSUE -> (WAIT_ACK) with a read-ack timeout.
module device_arbiter_rr
  import arbiter_pkg::*;
#(
  parameter int unsigned           NUM_CONTROLLERS = 2,
  parameter int unsigned           ADDRESS_WIDTH   = 25,
  parameter int unsigned           DATA_WIDTH      = 32,
  parameter int unsigned           BANK_WIDTH      = DEFAULT_BANK_WIDTH,
  parameter int unsigned           DEVICE_BANK     = DEFAULT_DEVICE_BANK,
  parameter int unsigned           ROUND_ROBIN     = 1,
  parameter int unsigned           TIMEOUT         = 1024,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA    = '1
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset_n,
  input  logic [NUM_CONTROLLERS-1:0]            i_request,
  input  logic [NUM_CONTROLLERS-1:0]            i_write,
  output logic [NUM_CONTROLLERS-1:0]            o_busy,
  output logic [NUM_CONTROLLERS-1:0]            o_ack,
  input  logic [NUM_CONTROLLERS*BANK_WIDTH-1:0] i_bank,
  input  logic [NUM_CONTROLLERS*ADDRESS_WIDTH-1:0] i_address,
  input  logic [NUM_CONTROLLERS*DATA_WIDTH-1:0] i_data,
  output logic [NUM_CONTROLLERS*DATA_WIDTH-1:0] o_data,
  output logic                                  o_device_request,
  output logic                                  o_device_write,
  input  logic                                  i_device_busy,
  input  logic                                  i_device_ack,
  output logic [ADDRESS_WIDTH-1:0]              o_device_address,
  input  logic [DATA_WIDTH-1:0]                 i_device_data,
  output logic [DATA_WIDTH-1:0]                 o_device_data,
  output logic                                  o_timeout
);

  localparam int unsigned IW     = index_width(NUM_CONTROLLERS);
  localparam int unsigned CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          TMO_EN = (TIMEOUT != 0);
  localparam logic [CW-1:0] TMO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  arb_state_t              state;
  logic [IW-1:0]           last_grant;
  logic [IW-1:0]           grant;
  logic [CW-1:0]           cnt;
  logic [NUM_CONTROLLERS-1:0] match;
  logic [IW-1:0]           sel_winner;
  logic                    sel_valid;
  logic                    accept;
  logic                    tmo_hit;
  logic                    resp;
  logic [DATA_WIDTH-1:0]   resp_data;

  // Only requests addressed to this device's bank take part.
  always_comb begin
    match = '0;
    for (int unsigned k = 0; k < NUM_CONTROLLERS; k++) begin
      match[k] = i_request[k] && (i_bank[k*BANK_WIDTH +: BANK_WIDTH] == BANK_WIDTH'(DEVICE_BANK));
    end
  end

  arbiter_rr_select #(
    .NUM_CONTROLLERS (NUM_CONTROLLERS),
    .INDEX_WIDTH     (IW)
  ) u_select (
    .match       (match),
    .last_grant  (last_grant),
    .round_robin (ROUND_ROBIN != 0),
    .winner      (sel_winner),
    .valid       (sel_valid)
  );

  // No accept can happen while reset is held, so every matching controller
  // is held off until the arbiter is out of reset.
  always_comb begin
    accept = (state == IDLE) && i_reset_n && sel_valid;
    o_busy = match;
    if (accept) begin
      o_busy[sel_winner] = 1'b0;
    end
  end

  // Read completion: a device ack wins over a timeout in the same cycle.
  always_comb begin
    tmo_hit   = TMO_EN && (cnt == TMO_LAST);
    resp      = (state == WAIT_ACK) && (i_device_ack || tmo_hit);
    o_timeout = (state == WAIT_ACK) && !i_device_ack && tmo_hit;
    resp_data = i_device_ack ? i_device_data : TIMEOUT_DATA;
    o_ack     = '0;
    o_data    = '0;
    if (resp) begin
      o_ack[grant] = 1'b1;
      for (int unsigned k = 0; k < NUM_CONTROLLERS; k++) begin
        o_data[k*DATA_WIDTH +: DATA_WIDTH] = resp_data;
      end
    end
  end

  assign o_device_request = (state == ISSUE);

  // Transaction state machine with registered device-side fields.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state            <= IDLE;
      last_grant       <= IW'(NUM_CONTROLLERS - 1);
      grant            <= '0;
      cnt              <= '0;
      o_device_write   <= 1'b0;
      o_device_address <= '0;
      o_device_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid) begin
            grant            <= sel_winner;
            last_grant       <= sel_winner;
            o_device_write   <= i_write[sel_winner];
            o_device_address <= i_address[sel_winner*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            o_device_data    <= i_data[sel_winner*DATA_WIDTH +: DATA_WIDTH];
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          if (!i_device_busy) begin
            if (o_device_write) begin
              state <= IDLE;
            end else begin
              cnt   <= '0;
              state <= WAIT_ACK;
            end
          end
        end
        WAIT_ACK: begin
          if (i_device_ack || tmo_hit) begin
            state <= IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_device_arbiter_rr.sv
// Bench: randomized traffic on a 3-controller round-robin arbiter with a
// short timeout, checked by a scoreboard, plus a directed sequence on a
// 2-controller fixed-priority instance with the timeout disabled.
module tb_device_arbiter_rr;

  localparam int N   = 3;
  localparam int AW  = 25;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int TMO = 8;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- round-robin instance ----------------
  logic          rst_n;
  logic [N-1:0]  req, wr, busy, ack;
  logic [N*BW-1:0] bank;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata, rdata;
  logic          dreq, dwr, dbusy, dack, tmo;
  logic [AW-1:0] daddr;
  logic [DW-1:0] ddin, ddout;

  device_arbiter_rr #(
    .NUM_CONTROLLERS (N),
    .ADDRESS_WIDTH   (AW),
    .DATA_WIDTH      (DW),
    .BANK_WIDTH      (BW),
    .DEVICE_BANK     (0),
    .ROUND_ROBIN     (1),
    .TIMEOUT         (TMO)
  ) dut (
    .i_clk            (clk),
    .i_reset_n        (rst_n),
    .i_request        (req),
    .i_write          (wr),
    .o_busy           (busy),
    .o_ack            (ack),
    .i_bank           (bank),
    .i_address        (addr),
    .i_data           (wdata),
    .o_data           (rdata),
    .o_device_request (dreq),
    .o_device_write   (dwr),
    .i_device_busy    (dbusy),
    .i_device_ack     (dack),
    .o_device_address (daddr),
    .i_device_data    (ddin),
    .o_device_data    (ddout),
    .o_timeout        (tmo)
  );

  // ---------------- fixed-priority instance ----------------
  logic          f_rst_n;
  logic [1:0]    f_req, f_wr, f_busy, f_ack;
  logic [2*BW-1:0] f_bank;
  logic [2*AW-1:0] f_addr;
  logic [2*DW-1:0] f_wdata, f_rdata;
  logic          f_dreq, f_dwr, f_dbusy, f_dack, f_tmo;
  logic [AW-1:0] f_daddr;
  logic [DW-1:0] f_ddin, f_ddout;

  device_arbiter_rr #(
    .NUM_CONTROLLERS (2),
    .ADDRESS_WIDTH   (AW),
    .DATA_WIDTH      (DW),
    .BANK_WIDTH      (BW),
    .DEVICE_BANK     (0),
    .ROUND_ROBIN     (0),
    .TIMEOUT         (0)
  ) dut_fixed (
    .i_clk            (clk),
    .i_reset_n        (f_rst_n),
    .i_request        (f_req),
    .i_write          (f_wr),
    .o_busy           (f_busy),
    .o_ack            (f_ack),
    .i_bank           (f_bank),
    .i_address        (f_addr),
    .i_data           (f_wdata),
    .o_data           (f_rdata),
    .o_device_request (f_dreq),
    .o_device_write   (f_dwr),
    .i_device_busy    (f_dbusy),
    .i_device_ack     (f_dack),
    .o_device_address (f_daddr),
    .i_device_data    (f_ddin),
    .o_device_data    (f_ddout),
    .o_timeout        (f_tmo)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [N-1:0] busy;
    logic         dreq;
    logic [N-1:0] ack;
    logic         tmo;
    logic         in_reset;
  } cyc_exp_t;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  cyc_exp_t      cyc_q[$];
  txn_t          dev_q[$];
  logic [DW-1:0] ack_q[$];

  int errors = 0;
  int checks = 0;
  bit drv_done = 1'b0;
  bit f_done   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Randomized controllers, device and reference model.
  initial begin
    bit            pend [N];
    logic          p_wr [N];
    logic [AW-1:0] p_addr [N];
    logic [DW-1:0] p_data [N];
    logic [BW-1:0] p_bank [N];
    int            m_phase;   // 0 free, 1 waiting for device to take it, 2 waiting for read data
    int unsigned   m_last, m_cur, m_waited;
    logic          m_wr;
    bit            do_reset, arm, found;
    logic [N-1:0]  mt;
    cyc_exp_t      e;
    txn_t          t;
    int unsigned   w;

    rst_n = 1'b0; req = '0; wr = '0; bank = '0; addr = '0; wdata = '0;
    dbusy = 1'b0; dack = 1'b0; ddin = '0;
    m_phase = 0; m_last = N - 1; m_cur = 0; m_waited = 0; m_wr = 1'b0; arm = 1'b0;
    for (int k = 0; k < N; k++) begin
      pend[k] = 1'b0; p_wr[k] = 1'b0; p_addr[k] = '0; p_data[k] = '0; p_bank[k] = '0;
    end

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (cyc % 150 == 75) arm = 1'b1;
      do_reset = (cyc < 2) || (arm && m_phase == 2);
      if (do_reset && cyc >= 2) arm = 1'b0;
      rst_n = !do_reset;

      for (int k = 0; k < N; k++) begin
        if (!pend[k]) begin
          if ($urandom_range(0, 2) == 0) begin
            pend[k]   = 1'b1;
            p_bank[k] = ($urandom_range(0, 5) == 0) ? BW'(1) : BW'(0);
            p_wr[k]   = 1'($urandom);
            p_addr[k] = AW'($urandom);
            p_data[k] = $urandom;
          end
        end else if ((p_bank[k] != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0)) begin
          pend[k] = 1'b0;
        end
        req[k] = pend[k];
        bank[k*BW +: BW]  = pend[k] ? p_bank[k] : BW'($urandom);
        wr[k]             = pend[k] ? p_wr[k]   : 1'($urandom);
        addr[k*AW +: AW]  = pend[k] ? p_addr[k] : AW'($urandom);
        wdata[k*DW +: DW] = pend[k] ? p_data[k] : $urandom;
      end
      dbusy = ($urandom_range(0, 2) == 0);
      dack  = (m_phase == 2) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 7) == 0);
      ddin  = $urandom;

      for (int k = 0; k < N; k++) mt[k] = pend[k] && (p_bank[k] == 0);
      e.busy = mt; e.dreq = 1'b0; e.ack = '0; e.tmo = 1'b0; e.in_reset = do_reset;

      if (do_reset) begin
        m_phase = 0;
        m_last  = N - 1;
      end else if (m_phase == 0) begin
        found = 1'b0;
        w = 0;
        for (int off = 1; off <= N; off++) begin
          if (!found && mt[(m_last + off) % N]) begin
            found = 1'b1;
            w = (m_last + off) % N;
          end
        end
        if (found) begin
          e.busy[w] = 1'b0;
          t.wr = p_wr[w]; t.addr = p_addr[w]; t.data = p_data[w];
          dev_q.push_back(t);
          m_cur = w; m_last = w; m_wr = p_wr[w];
          pend[w] = 1'b0;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        e.dreq = 1'b1;
        if (!dbusy) begin
          if (m_wr) m_phase = 0;
          else begin
            m_phase  = 2;
            m_waited = 0;
          end
        end
      end else begin
        if (dack) begin
          e.ack[m_cur] = 1'b1;
          ack_q.push_back(ddin);
          m_phase = 0;
        end else begin
          m_waited++;
          if (m_waited == TMO) begin
            e.ack[m_cur] = 1'b1;
            e.tmo = 1'b1;
            ack_q.push_back('1);
            m_phase = 0;
          end
        end
      end
      cyc_q.push_back(e);
    end
    drv_done = 1'b1;
  end

  // Monitor: samples outputs mid-cycle and compares against expectations.
  initial begin
    cyc_exp_t      e;
    txn_t          t;
    logic [DW-1:0] d;
    forever begin
      @(negedge clk);
      #3;
      if (cyc_q.size() != 0) begin
        e = cyc_q.pop_front();
        check("busy", 64'(busy), 64'(e.busy));
        check("dev_request", 64'(dreq), 64'(e.dreq));
        check("ack", 64'(ack), 64'(e.ack));
        check("timeout", 64'(tmo), 64'(e.tmo));
        if (e.in_reset) begin
          check("rst_dev_write", 64'(dwr), 64'd0);
          check("rst_dev_address", 64'(daddr), 64'd0);
          check("rst_dev_data", 64'(ddout), 64'd0);
          check("rst_read_data", 64'(rdata[DW-1:0]), 64'd0);
        end
        if (dreq && !dbusy) begin
          if (dev_q.size() == 0) begin
            check("dev_txn_expected", 64'd0, 64'd1);
          end else begin
            t = dev_q.pop_front();
            check("dev_write", 64'(dwr), 64'(t.wr));
            check("dev_address", 64'(daddr), 64'(t.addr));
            check("dev_data", 64'(ddout), 64'(t.data));
          end
        end
        if (ack != '0) begin
          if (ack_q.size() == 0) begin
            check("ack_expected", 64'd0, 64'd1);
          end else begin
            d = ack_q.pop_front();
            for (int k = 0; k < N; k++) check("read_data", 64'(rdata[k*DW +: DW]), 64'(d));
          end
        end
      end
    end
  end

  // Directed fixed-priority sequence; read latency well beyond any timeout.
  initial begin
    f_rst_n = 1'b0; f_req = '0; f_wr = '0; f_bank = '0; f_addr = '0; f_wdata = '0;
    f_dbusy = 1'b0; f_dack = 1'b0; f_ddin = '0;
    repeat (2) @(negedge clk);
    #3;
    check("fx_rst_dev_request", 64'(f_dreq), 64'd0);
    check("fx_rst_ack", 64'(f_ack), 64'd0);
    @(negedge clk); f_rst_n = 1'b1;

    @(negedge clk);
    f_req = 2'b11; f_wr = 2'b10;
    f_addr = {25'h00ABCD, 25'h12345};
    f_wdata = {32'h55AA0011, 32'h00000000};
    #3 check("fx_busy_first", 64'(f_busy), 64'b10);

    @(negedge clk); f_req = 2'b10;
    #3;
    check("fx_busy_issue", 64'(f_busy), 64'b10);
    check("fx_dev_request", 64'(f_dreq), 64'd1);
    check("fx_dev_address", 64'(f_daddr), 64'h12345);
    check("fx_dev_write", 64'(f_dwr), 64'd0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #3;
      check("fx_no_ack_wait", 64'(f_ack), 64'd0);
      check("fx_no_timeout", 64'(f_tmo), 64'd0);
      check("fx_busy_wait", 64'(f_busy), 64'b10);
    end

    @(negedge clk); f_dack = 1'b1; f_ddin = 32'hDEADBEEF;
    #3;
    check("fx_ack", 64'(f_ack), 64'b01);
    check("fx_data_lane0", 64'(f_rdata[DW-1:0]), 64'hDEADBEEF);
    check("fx_data_lane1", 64'(f_rdata[2*DW-1:DW]), 64'hDEADBEEF);

    @(negedge clk);
    f_dack = 1'b0; f_req = 2'b11; f_wr = 2'b11;
    f_addr[AW-1:0] = 25'h00777; f_wdata[DW-1:0] = 32'hCAFE0001;
    #3 check("fx_busy_fixed_prio", 64'(f_busy), 64'b10);

    @(negedge clk); f_req = 2'b10;
    #3;
    check("fx_wr_dev_write", 64'(f_dwr), 64'd1);
    check("fx_wr_dev_address", 64'(f_daddr), 64'h00777);
    check("fx_wr_dev_data", 64'(f_ddout), 64'hCAFE0001);

    @(negedge clk);
    #3 check("fx_busy_k1_accept", 64'(f_busy), 64'b00);

    @(negedge clk); f_req = 2'b00;
    #3;
    check("fx_k1_dev_address", 64'(f_daddr), 64'h00ABCD);
    check("fx_k1_dev_data", 64'(f_ddout), 64'h55AA0011);

    @(negedge clk); f_dack = 1'b1;
    #3;
    check("fx_idle_dev_request", 64'(f_dreq), 64'd0);
    check("fx_stale_ack", 64'(f_ack), 64'd0);
    @(negedge clk); f_dack = 1'b0;
    f_done = 1'b1;
  end

  // End of run: everything predicted must have been observed.
  initial begin
    wait (drv_done && f_done);
    @(negedge clk);
    #4;
    check("cyc_q_drained", 64'(cyc_q.size()), 64'd0);
    check("dev_q_drained", 64'(dev_q.size()), 64'd0);
    check("ack_q_drained", 64'(ack_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
